blk_pack_buf: RTL and testbench

Upstream feeder and controller for the 128-bit distributed block RAM (`rams_dist`, D_WIDTH=128) in the ChaCha20-Poly1305 datapath.
- Packs a 32-bit little-endian word stream into 128-bit blocks and writes each completed block into the RAM through the RAM's write port.
- Tracks per-block byte length and last flag, and manages RAM occupancy as a FIFO.
- Presents RAM entries, in order, to the downstream Poly1305/ChaCha20 consumer over a valid/ready handshake.

---
 rtl/blk_pack_buf.sv | 119 +++++++++++
 tb/tb_blk_pack_buf.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_pack_buf.sv
// blk_pack_buf: packs a 32-bit LE word stream into 128-bit blocks, writes them
// to an external distributed RAM run as a FIFO. Optional macro: BLK_PAD_ZERO_EN.
module blk_pack_buf #(
  parameter int A_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  input  logic [2:0]         in_bytes,
  output logic               ram_we,
  output logic [A_WIDTH-1:0] ram_a,
  output logic [127:0]       ram_di,
  output logic [A_WIDTH-1:0] ram_dpra,
  input  logic [127:0]       ram_dpo,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [127:0]       blk_data,
  output logic [4:0]         blk_len,
  output logic               blk_last
);
  localparam int unsigned      DEPTH = 2**A_WIDTH;
  localparam logic [A_WIDTH:0] FULL  = (A_WIDTH+1)'(DEPTH);

  logic [1:0]         wcnt_q, wcnt_d;
  logic [95:0]        stage_q, stage_d;
  logic [A_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [A_WIDTH:0]   count_q, count_d;
  logic [4:0]         len_q [DEPTH];
  logic               last_q [DEPTH];

  logic               acc, push, pop;
  logic [2:0]         b;
  logic [4:0]         len_new;
  logic [127:0]       merged;

  // in_ready depends only on registered occupancy, so a pop never frees a slot
  // for the same cycle.
  assign in_ready  = (count_q != FULL);
  assign acc       = in_valid & in_ready;
  assign push      = acc & ((wcnt_q == 2'd3) | in_last);
  assign blk_valid = (count_q != '0);
  assign pop       = blk_valid & blk_ready;

  assign ram_we    = push & rst_n;
  assign ram_a     = wr_ptr_q;
  assign ram_dpra  = rd_ptr_q;
  assign blk_data  = ram_dpo;
  assign blk_len   = len_q[rd_ptr_q];
  assign blk_last  = last_q[rd_ptr_q];

  always_comb begin
    b = 3'd4;
    if (in_last && in_bytes >= 3'd1 && in_bytes <= 3'd4)
      b = in_bytes;
    len_new = {1'b0, wcnt_q, 2'b00} + {2'b00, b};
  end

  always_comb begin
    merged = {32'd0, stage_q};
    merged[{wcnt_q, 5'd0} +: 32] = in_data;
`ifdef BLK_PAD_ZERO_EN
    for (int unsigned i = 0; i < 16; i++)
      if (5'(i) >= len_new)
        merged[8*i +: 8] = 8'h00;
`endif
    ram_di = merged;
  end

  always_comb begin
    stage_d = stage_q;
    wcnt_d  = wcnt_q;
    if (push) begin
      wcnt_d = '0;
`ifdef BLK_PAD_ZERO_EN
      stage_d = '0;
`endif
    end else if (acc) begin
      stage_d[{wcnt_q, 5'd0} +: 32] = in_data;
      wcnt_d = wcnt_q + 2'd1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q   <= '0;
      stage_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      stage_q <= stage_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Side metadata is not reset; it is only read once count marks it occupied.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      len_q[wr_ptr_q]  <= len_new;
      last_q[wr_ptr_q] <= in_last;
    end
  end

endmodule

// File: tb/tb_blk_pack_buf.sv
// Bench for blk_pack_buf: directed cases plus random traffic scored against a
// word-queue reference model; includes a behavioural async-read RAM.
`timescale 1ns/1ps
module tb_blk_pack_buf;
  localparam int A_WIDTH = 3;
  localparam int DEPTH   = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [31:0]        in_data = '0;
  logic               in_last = 1'b0;
  logic [2:0]         in_bytes = 3'd4;
  logic               ram_we;
  logic [A_WIDTH-1:0] ram_a;
  logic [127:0]       ram_di;
  logic [A_WIDTH-1:0] ram_dpra;
  logic [127:0]       ram_dpo;
  logic               blk_valid;
  logic               blk_ready;
  logic [127:0]       blk_data;
  logic [4:0]         blk_len;
  logic               blk_last;

  logic rdy_rand  = 1'b0;
  logic rdy_force = 1'b0;

  blk_pack_buf #(.A_WIDTH(A_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
    .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_dpra(ram_dpra), .ram_dpo(ram_dpo),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_len(blk_len), .blk_last(blk_last)
  );

  logic [127:0] mem [DEPTH];
  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_di;
  assign ram_dpo = mem[ram_dpra];

  always #5 clk = ~clk;

  initial begin
    blk_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      blk_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   len;
    logic         last;
  } blk_t;

  blk_t        exp_q[$];
  logic [31:0] cur_w[$];
  int unsigned wr_tot = 0;
  int unsigned rd_tot = 0;

  function automatic logic [127:0] len_mask(input int unsigned len);
    logic [127:0] m = '0;
    for (int unsigned i = 0; i < 16; i++)
      if (i < len) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [127:0] cmp_mask(input int unsigned len);
`ifdef BLK_PAD_ZERO_EN
    return '1;
`else
    return len_mask(len);
`endif
  endfunction

  // Reference model, evaluated mid-cycle on the values that the next edge uses.
  always @(negedge clk) begin
    blk_t        hd, nb;
    logic        ev, er, wr;
    int unsigned bb;
    if (!rst_n) begin
      chk("rst_blk_valid", blk_valid, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_a", ram_a, 0);
      chk("rst_ram_dpra", ram_dpra, 0);
      chk("rst_in_ready", in_ready, 1);
      exp_q.delete();
      cur_w.delete();
      wr_tot = 0;
      rd_tot = 0;
    end else begin
      ev = (exp_q.size() != 0);
      er = (exp_q.size() != DEPTH);
      chk("blk_valid", blk_valid, ev);
      chk("in_ready", in_ready, er);
      chk("ram_a", ram_a, wr_tot % DEPTH);
      chk("ram_dpra", ram_dpra, rd_tot % DEPTH);
      if (ev) begin
        hd = exp_q[0];
        chk("blk_data", blk_data & cmp_mask(hd.len), hd.data & cmp_mask(hd.len));
        chk("blk_len", blk_len, hd.len);
        chk("blk_last", blk_last, hd.last);
        if (blk_ready) begin
          void'(exp_q.pop_front());
          rd_tot++;
        end
      end
      wr = 1'b0;
      if (in_valid && er) begin
        cur_w.push_back(in_data);
        if (in_last || cur_w.size() == 4) begin
          wr = 1'b1;
          nb.data = '0;
          for (int i = 0; i < cur_w.size(); i++) nb.data[32*i +: 32] = cur_w[i];
          bb = (in_last && in_bytes >= 1 && in_bytes <= 4) ? in_bytes : 4;
          nb.len  = 5'(4 * (cur_w.size() - 1) + bb);
          nb.data = nb.data & len_mask(nb.len);
          nb.last = in_last;
        end
      end
      chk("ram_we", ram_we, wr);
      if (wr) begin
        chk("ram_di", ram_di & cmp_mask(nb.len), nb.data & cmp_mask(nb.len));
        exp_q.push_back(nb);
        wr_tot++;
        cur_w.delete();
      end
    end
  end

  task automatic push_word(input logic [31:0] d, input logic last, input logic [2:0] nbytes);
    int unsigned t = 0;
    logic ok;
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nbytes;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; t++;
    end while (!ok && t < 200);
    chk("push_accept", ok, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int unsigned t = 0;
    rdy_force = 1'b1;
    @(negedge clk);
    while (blk_valid && t < 200) begin @(negedge clk); t++; end
    chk("drain_empty", blk_valid, 0);
    @(posedge clk); #1;
    rdy_force = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;

    // Full-block packing
    push_word(32'h03020100, 0, 4);
    push_word(32'h07060504, 0, 4);
    push_word(32'h0B0A0908, 0, 4);
    push_word(32'h0F0E0D0C, 1, 4);
    @(negedge clk);
    chk("full_valid", blk_valid, 1);
    chk("full_data", blk_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    chk("full_len", blk_len, 16);
    chk("full_last", blk_last, 1);
    @(posedge clk); #1;
    drain();

    // Partial block
    push_word(32'h44332211, 0, 4);
    push_word(32'h000000AA, 1, 1);
    @(negedge clk);
    chk("part_len", blk_len, 5);
    chk("part_last", blk_last, 1);
    chk("part_data_lo", blk_data[39:0], 40'hAA44332211);
`ifdef BLK_PAD_ZERO_EN
    chk("part_data_pad", blk_data[127:40], 88'h0);
`endif
    @(posedge clk); #1;
    drain();

    // Fill under backpressure, then pop at full with a word pending
    for (int k = 0; k < 4 * DEPTH; k++)
      push_word($urandom, (k % 4) == 3, 4);
    @(negedge clk);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_valid", blk_valid, 1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_last = 1'b0; in_bytes = 3'd4;
    rdy_force = 1'b1;
    @(negedge clk);
    chk("pop_full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rdy_force = 1'b0;
    @(negedge clk);
    chk("after_pop_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    push_word(32'h11112222, 0, 4);
    push_word(32'h33334444, 0, 4);
    push_word(32'h55556666, 1, 4);
    @(negedge clk);
    chk("refill_in_ready", in_ready, 0);
    @(posedge clk); #1;
    drain();

    // in_bytes edge values
    push_word(32'h11111111, 0, 4);
    push_word(32'h22222222, 1, 0);
    @(negedge clk);
    chk("bytes0_len", blk_len, 8);
    @(posedge clk); #1;
    drain();
    push_word(32'h33333333, 1, 7);
    @(negedge clk);
    chk("bytes7_len", blk_len, 4);
    @(posedge clk); #1;
    drain();

    // Reset mid-block
    for (int k = 0; k < 14; k++)
      push_word($urandom, (k % 4) == 3, 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", blk_valid, 0);
    chk("midrst_ram_a", ram_a, 0);
    chk("midrst_ram_dpra", ram_dpra, 0);
    cycles(2);
    rst_n = 1'b1;
    push_word(32'hA3A2A1A0, 0, 4);
    push_word(32'hA7A6A5A4, 0, 4);
    push_word(32'hABAAA9A8, 0, 4);
    in_valid = 1'b1; in_data = 32'hAFAEADAC; in_last = 1'b1; in_bytes = 3'd4;
    @(negedge clk);
    chk("post_rst_we", ram_we, 1);
    chk("post_rst_addr", ram_a, 0);
    chk("post_rst_di", ram_di, 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("post_rst_data", blk_data, 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0);
    @(posedge clk); #1;
    drain();

    // Random traffic with random backpressure
    rdy_rand = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) cycles(1);
      else push_word($urandom, $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)));
    end
    push_word($urandom, 1, 4);
    rdy_rand = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
